// File: rtl/nibble_serial_adder_ctrl_if.sv
// Requester-side handshake and operand/result bus for the nibble-serial adder controller.
// The requester drives the master modport and the controller implements the slave modport.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic             c_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, sub, c_in, a, b,
    input  busy, done, sum, c_out, ovf
  );

  modport slave (
    input  start, sub, c_in, a, b,
    output busy, done, sum, c_out, ovf
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds or subtracts WIDTH-bit operands through one 4-bit ripple slice, one nibble per cycle,
// LSB nibble first, with a registered carry between nibbles.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  nibble_serial_adder_ctrl_if.slave bus
);

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] sum_r;
  logic             c_out_r;
  logic             ovf_r;
  logic [5:0]       slice;
  logic             accept;
  logic             last;
  logic             busy_r;
  logic             done_r;

  // Ripple slice result: {carry out of bit 3, carry out of bit 2, 4-bit sum}.
  function automatic logic [5:0] slice_add(input logic [3:0] x, input logic [3:0] y,
                                           input logic cin);
    logic [3:0] lo;
    logic [1:0] hi;
    lo = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b000, cin};
    hi = {1'b0, x[3]} + {1'b0, y[3]} + {1'b0, lo[3]};
    return {hi[1], lo[3], hi[0], lo[2:0]};
  endfunction

  assign accept = bus.start && (state == IDLE || state == DONE);
  assign last   = (idx == LAST);
  assign slice  = slice_add(a_lat[{idx, 2'b00} +: 4], b_lat[{idx, 2'b00} +: 4], carry);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_r = 1'b0;
    done_r = 1'b0;
    case (state)
      RUN:     busy_r = 1'b1;
      DONE:    done_r = 1'b1;
      default: ;
    endcase
  end

  // Operand capture; subtraction is folded in as a + ~b + 1.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_lat <= bus.a;
      b_lat <= bus.sub ? ~bus.b : bus.b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry   <= 1'b0;
      idx     <= '0;
      sum_r   <= '0;
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept) begin
      carry <= bus.sub ? 1'b1 : bus.c_in;
      idx   <= '0;
    end else if (state == RUN) begin
      sum_r[{idx, 2'b00} +: 4] <= slice[3:0];
      carry                    <= slice[5];
      idx                      <= idx + IDX_W'(1);
      if (last) begin
        c_out_r <= slice[5];
        ovf_r   <= slice[5] ^ slice[4];
      end
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.sum   = sum_r;
  assign bus.c_out = c_out_r;
  assign bus.ovf   = ovf_r;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl at WIDTH=16 with hand-computed results.
module tb_nibble_serial_adder_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  nibble_serial_adder_ctrl_if #(.WIDTH(16)) bus ();

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic cin);
    bus.a    = a;
    bus.b    = b;
    bus.sub  = sub;
    bus.c_in = cin;
  endtask

  // Wait for busy to drop; returns number of busy cycles observed.
  task automatic wait_busy(output int cyc);
    cyc = 0;
    while (bus.busy && cyc < 20) begin
      chk("busy_done_excl", {31'd0, bus.done}, 32'd0);
      tick();
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic cin, input logic [15:0] exp_sum,
                        input logic exp_c, input logic exp_v);
    int cyc;
    set_op(a, b, sub, cin);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    wait_busy(cyc);
    chk({tag, "_lat"}, cyc, 32'd4);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_sum"}, {16'd0, bus.sum}, {16'd0, exp_sum});
    chk({tag, "_cout"}, {31'd0, bus.c_out}, {31'd0, exp_c});
    chk({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, exp_v});
    tick();
    chk({tag, "_done_clr"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int cyc;
    bus.start = 1'b0;
    set_op(16'h0, 16'h0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst_busy",  {31'd0, bus.busy},  32'd0);
    chk("rst_done",  {31'd0, bus.done},  32'd0);
    chk("rst_sum",   {16'd0, bus.sum},   32'd0);
    chk("rst_cout",  {31'd0, bus.c_out}, 32'd0);
    chk("rst_ovf",   {31'd0, bus.ovf},   32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    run_op("add1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("add2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add3", 16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    run_op("sub1", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub2", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // Start pulsed during RUN must be ignored.
    set_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    set_op(16'hAAAA, 16'h5555, 1'b1, 1'b1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ign_busy", {31'd0, bus.busy}, 32'd1);
    wait_busy(cyc);
    chk("ign_lat", cyc, 32'd2);
    chk("ign_done", {31'd0, bus.done}, 32'd1);
    chk("ign_sum", {16'd0, bus.sum}, 32'h0002);
    tick();
    chk("ign_done_once", {31'd0, bus.done}, 32'd0);
    chk("ign_no_restart", {31'd0, bus.busy}, 32'd0);

    // Back-to-back: start held in DONE.
    set_op(16'h0003, 16'h0004, 1'b0, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_busy(cyc);
    chk("b2b_done1", {31'd0, bus.done}, 32'd1);
    chk("b2b_sum1", {16'd0, bus.sum}, 32'h0007);
    set_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("b2b_busy2", {31'd0, bus.busy}, 32'd1);
    chk("b2b_done_lo", {31'd0, bus.done}, 32'd0);
    wait_busy(cyc);
    chk("b2b_lat2", cyc, 32'd4);
    chk("b2b_done2", {31'd0, bus.done}, 32'd1);
    chk("b2b_sum2", {16'd0, bus.sum}, 32'h0100);
    tick();

    // Asynchronous reset in the middle of RUN.
    set_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("mrst_busy", {31'd0, bus.busy},  32'd0);
    chk("mrst_done", {31'd0, bus.done},  32'd0);
    chk("mrst_sum",  {16'd0, bus.sum},   32'd0);
    chk("mrst_cout", {31'd0, bus.c_out}, 32'd0);
    chk("mrst_ovf",  {31'd0, bus.ovf},   32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mrst_no_done", {31'd0, bus.done | bus.busy}, 32'd0);
    end
    run_op("post_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Multi-cycle controller that adds or subtracts WIDTH-bit operands by running one internal 4-bit ripple full-adder slice once per cycle, least-significant nibble first, with a registered carry between nibbles. It sits between a requester using a start/busy/done handshake and the shared 4-bit adder datapath. It trades latency (WIDTH/4 cycles) for a single small adder slice.

## Interface
- WIDTH, 16, operand/result width in bits; multiple of 4, minimum 4. N = WIDTH/4 nibbles.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = a + b + c_in; 1 = a - b (c_in ignored).
- c_in  input  1  carry-in for add.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result register.
- c_out  output  1  carry out of bit WIDTH-1. For sub, 1 means no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: busy=0, done=0, sum=0, c_out=0, ovf=0, nibble index=0, carry reg=0.
- IDLE or DONE with start=1 at an edge:
  - latch a, and b (or ~b when sub=1);
  - carry reg <= (sub ? 1 : c_in);
  - index <= 0; go to RUN.
- DONE with start=0: go to IDLE.
- RUN, each edge:
  - slice adds latched a nibble[index] + b nibble[index] + carry reg;
  - sum nibble[index] <= slice sum;
  - carry reg <= slice bit-3 carry;
  - index <= index+1.
- On the edge with index = N-1, additionally:
  - c_out <= slice bit-3 carry;
  - ovf <= bit-2 carry XOR bit-3 carry;
  - go to DONE.
- start while in RUN is ignored; there is no queueing. a, b, sub and c_in may change freely after capture.
- sum is partially updated during RUN. It is valid only while done=1 and holds unchanged until the next accepted start.
- c_out and ovf change only on the final RUN edge.
- Asynchronous reset in any state forces all reset values immediately and aborts the operation; no done pulse follows.
- WIDTH=4: RUN lasts exactly one cycle.

## Timing
- Start accepted at edge E0 → busy=1 after E0.
- Nibble k is computed at edge E(k+1).
- After edge EN: busy=0, done=1, and sum/c_out/ovf are valid. Latency is N cycles from the accept edge.
- After edge E(N+1): done=0 (IDLE), unless start=1 at E(N+1). In that case a new operation is accepted and busy=1, giving back-to-back throughput of one operation per N+1 cycles.
- busy and done are never high together. done is never high for more than one consecutive cycle.
- Outputs are registered with no combinational input-to-output paths.

## Test plan (WIDTH=16, N=4)
- Add 0x1234 + 0x4321, c_in=0 → after 4 edges done=1, sum=0x5555, c_out=0, ovf=0. busy high for exactly 4 cycles.
- Add 0xFFFF + 0x0001, c_in=0 → sum=0x0000, c_out=1, ovf=0. Also 0x7FFF + 0x0000, c_in=1 → sum=0x8000, c_out=0, ovf=1.
- Sub 0x0005 - 0x0007 → sum=0xFFFE, c_out=0, ovf=0. Sub 0x8000 - 0x0001 → sum=0x7FFF, c_out=1, ovf=1.
- Pulse start with new operands during cycle 2 of RUN for 0x0001+0x0001 → ignored; result 0x0002, done once.
- Hold start=1 in DONE with operands 0x00FF + 0x0001 → busy the next cycle; second result 0x0100 after 4 further edges.
- Assert reset mid-RUN (after 2 edges) → busy=0, done=0, sum=0, c_out=0, ovf=0 immediately. No done pulse; a subsequent start completes normally.
